// File: rtl/axi_lite_csr_bank.sv
// axi_lite_csr_bank: AXI4-Lite bank of software RW registers and hardware RO registers with write/read pulses
module axi_lite_csr_bank #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_RW_REG = 33,
    parameter int C_NUM_RO_REG = 4,
    parameter int C_ADDR_WIDTH = $clog2(C_NUM_RW_REG + C_NUM_RO_REG) + 2
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_areset,
    input  logic [C_ADDR_WIDTH-1:0]                s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]                s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]              s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]                s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]                s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic [C_NUM_RW_REG*C_DATA_WIDTH-1:0]   rw_regs_out,
    input  logic [C_NUM_RO_REG*C_DATA_WIDTH-1:0]   ro_regs_in,
    output logic [C_NUM_RW_REG-1:0]                wr_pulse,
    output logic [C_NUM_RO_REG-1:0]                rd_pulse
);
    localparam int SW = C_DATA_WIDTH / 8;
    localparam int IW = C_ADDR_WIDTH - 2;
    localparam int NRW = C_NUM_RW_REG;
    localparam int NMAP = C_NUM_RW_REG + C_NUM_RO_REG;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;
    logic [IW-1:0] aw_idx, ar_idx;
    logic aw_held, w_held;
    logic [C_DATA_WIDTH-1:0] w_data, rd_value;
    logic [SW-1:0] w_strb;
    logic rd_is_ro;
    logic unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [1:0] resp_for(input logic [IW-1:0] idx);
        return int'(idx) < NRW ? 2'b00 : int'(idx) < NMAP ? 2'b10 : 2'b11;
    endfunction

    always_ff @(posedge s_axi_aclk) begin
        wr_pulse <= '0;
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            rw_regs_out   <= '0;
        end else if (w_state == W_RESP) begin
            if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                w_state      <= W_IDLE;
            end
        end else if (aw_held && w_held) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= resp_for(aw_idx);
            w_state      <= W_RESP;
            if (int'(aw_idx) < NRW) begin
                wr_pulse <= C_NUM_RW_REG'(1) << aw_idx;
                for (int b = 0; b < SW; b++)
                    if (w_strb[b]) rw_regs_out[int'(aw_idx)*C_DATA_WIDTH + b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end else begin
            // each channel's ready stays low from its own handshake until the response completes
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held       <= 1'b1;
                aw_idx        <= s_axi_awaddr[C_ADDR_WIDTH-1:2];
                s_axi_awready <= 1'b0;
            end else begin
                s_axi_awready <= !aw_held;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held       <= 1'b1;
                w_data       <= s_axi_wdata;
                w_strb       <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end else begin
                s_axi_wready <= !w_held;
            end
        end
    end

    always_comb begin
        rd_is_ro = int'(ar_idx) >= NRW && int'(ar_idx) < NMAP;
        rd_value = int'(ar_idx) < NRW ? rw_regs_out[int'(ar_idx)*C_DATA_WIDTH +: C_DATA_WIDTH] :
                   rd_is_ro ? ro_regs_in[(int'(ar_idx) - NRW)*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
    end

    always_ff @(posedge s_axi_aclk) begin
        rd_pulse <= '0;
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
        end else if (r_state == R_IDLE) begin
            if (s_axi_arvalid && s_axi_arready) begin
                ar_idx        <= s_axi_araddr[C_ADDR_WIDTH-1:2];
                s_axi_arready <= 1'b0;
                r_state       <= R_LOAD;
            end else begin
                s_axi_arready <= 1'b1;
            end
        end else if (r_state == R_LOAD) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= resp_for(ar_idx);
            s_axi_rdata  <= rd_value;
            r_state      <= R_RESP;
            if (rd_is_ro) rd_pulse <= C_NUM_RO_REG'(1) << (int'(ar_idx) - NRW);
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            r_state      <= R_IDLE;
        end
    end
endmodule
